// File: rtl/conv2d_scheduler_if.sv
// Handshake and memory-address bundle between the Conv2d scheduler (master)
// and the Conv2d datapath / memories plus the block that launches maps (slave).
interface conv2d_scheduler_if #(
  parameter int ADDR_BIT = 10
);
  logic                start;
  logic                mode;
  logic                conv_clr;
  logic                conv_en;
  logic                conv_bias;
  logic [ADDR_BIT-1:0] in_mem_addr;
  logic [ADDR_BIT-1:0] w_mem_addr;
  logic [ADDR_BIT-1:0] out_mem_addr;
  logic                out_mem_we;
  logic                busy;
  logic                done;

  modport master (
    input  start, mode,
    output conv_clr, conv_en, conv_bias, in_mem_addr, w_mem_addr,
           out_mem_addr, out_mem_we, busy, done
  );

  modport slave (
    output start, mode,
    input  conv_clr, conv_en, conv_bias, in_mem_addr, w_mem_addr,
           out_mem_addr, out_mem_we, busy, done
  );
endinterface

// File: rtl/conv2d_scheduler.sv
// Conv2d address/control sequencer: raster-scans a KxK window over a DxD map.
// Optional bias step (w_mem_addr=K*K) is enabled by defining CONV2D_SCHED_BIAS_EN.
module conv2d_scheduler #(
  parameter int ADDR_BIT   = 10,
  parameter int KERNEL_DIM = 5,
  parameter int IN_DIM_L0  = 28,
  parameter int IN_DIM_L1  = 12
) (
  input logic                  clk,
  input logic                  rst,
  conv2d_scheduler_if.master   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_BIAS  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

`ifdef CONV2D_SCHED_BIAS_EN
  localparam logic [2:0] READ_EXIT = S_BIAS;
`else
  localparam logic [2:0] READ_EXIT = S_DRAIN;
`endif

  localparam logic [ADDR_BIT-1:0] K_W         = ADDR_BIT'(KERNEL_DIM);
  localparam logic [ADDR_BIT-1:0] K_LAST      = ADDR_BIT'(KERNEL_DIM - 1);
  localparam logic [ADDR_BIT-1:0] W_BIAS      = ADDR_BIT'(KERNEL_DIM * KERNEL_DIM);
  localparam logic [ADDR_BIT-1:0] DIM_L0      = ADDR_BIT'(IN_DIM_L0);
  localparam logic [ADDR_BIT-1:0] DIM_L1      = ADDR_BIT'(IN_DIM_L1);
  localparam logic [ADDR_BIT-1:0] O_LAST_L0   = ADDR_BIT'(IN_DIM_L0 - KERNEL_DIM);
  localparam logic [ADDR_BIT-1:0] O_LAST_L1   = ADDR_BIT'(IN_DIM_L1 - KERNEL_DIM);
  localparam logic [ADDR_BIT-1:0] PIX_LAST_L0 =
    ADDR_BIT'((IN_DIM_L0 - KERNEL_DIM + 1) * (IN_DIM_L0 - KERNEL_DIM + 1) - 1);
  localparam logic [ADDR_BIT-1:0] PIX_LAST_L1 =
    ADDR_BIT'((IN_DIM_L1 - KERNEL_DIM + 1) * (IN_DIM_L1 - KERNEL_DIM + 1) - 1);

  logic [2:0]          state;
  logic                mode_q;
  logic [ADDR_BIT-1:0] ox, oy, kx, ky, wr_ptr;
  logic                en_q;

  logic [ADDR_BIT-1:0] dim, o_last, pix_last;

  // Geometry follows the layer latched at start, so mode changes mid-map are harmless.
  assign dim      = mode_q ? DIM_L1      : DIM_L0;
  assign o_last   = mode_q ? O_LAST_L1   : O_LAST_L0;
  assign pix_last = mode_q ? PIX_LAST_L1 : PIX_LAST_L0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain updates within a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      mode_q <= 1'b0;
      ox     <= '0;
      oy     <= '0;
      kx     <= '0;
      ky     <= '0;
      wr_ptr <= '0;
      en_q   <= 1'b0;
    end else begin
      // MAC enable tracks the read-data latency of the memories.
      en_q <= (state == S_READ) || (state == S_BIAS);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_CLEAR;
            mode_q <= bus.mode;
            ox     <= '0;
            oy     <= '0;
            kx     <= '0;
            ky     <= '0;
            wr_ptr <= '0;
          end
        end
        S_CLEAR: state <= S_READ;
        S_READ: begin
          if (kx == K_LAST) begin
            kx <= '0;
            if (ky == K_LAST) begin
              ky    <= '0;
              state <= READ_EXIT;
            end else begin
              ky <= ky + 1'b1;
            end
          end else begin
            kx <= kx + 1'b1;
          end
        end
        S_BIAS:  state <= S_DRAIN;
        S_DRAIN: state <= S_WRITE;
        S_WRITE: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (ox == o_last) begin
            ox <= '0;
            oy <= oy + 1'b1;
          end else begin
            ox <= ox + 1'b1;
          end
          state <= (wr_ptr == pix_last) ? S_DONE : S_CLEAR;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CONV2D_SCHED_BIAS_EN
  logic bias_q;

  always_ff @(posedge clk) begin
    if (rst) bias_q <= 1'b0;
    else     bias_q <= (state == S_BIAS);
  end

  assign bus.conv_bias = bias_q;
`else
  assign bus.conv_bias = 1'b0;
`endif

  // NOTE: every output gets a default before the case, so no latch is inferred.
  always_comb begin
    bus.conv_clr     = (state == S_CLEAR);
    bus.conv_en      = en_q;
    bus.busy         = (state != S_IDLE);
    bus.done         = (state == S_DONE);
    bus.out_mem_we   = (state == S_WRITE);
    bus.in_mem_addr  = '0;
    bus.w_mem_addr   = '0;
    bus.out_mem_addr = '0;
    case (state)
      S_READ: begin
        bus.in_mem_addr = (oy + ky) * dim + (ox + kx);
        bus.w_mem_addr  = ky * K_W + kx;
      end
      S_BIAS:  bus.w_mem_addr   = W_BIAS;
      S_WRITE: bus.out_mem_addr = wr_ptr;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv2d_scheduler.sv
// Self-checking bench for conv2d_scheduler: reset/start vectors, full-map traces
// against a cycle-level model built from the window arithmetic, random start/mode noise.
module tb_conv2d_scheduler;

  localparam int AW  = 10;
  localparam int K   = 5;
  localparam int D0  = 28;
  localparam int D1  = 12;
`ifdef CONV2D_SCHED_BIAS_EN
  localparam int BIAS = 1;
`else
  localparam int BIAS = 0;
`endif

  typedef struct packed {
    logic          clr;
    logic          en;
    logic          bias;
    logic [AW-1:0] in_addr;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] out_addr;
    logic          we;
    logic          busy;
    logic          done;
  } outs_t;

  typedef struct {
    logic  rst;
    logic  start;
    logic  mode;
    outs_t exp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  int tr_mism, tr_writes, tr_dones, tr_bias, tr_done_cyc, tr_cyc, tr_max_in;

  conv2d_scheduler_if #(.ADDR_BIT(AW)) bus ();

  conv2d_scheduler #(
    .ADDR_BIT  (AW),
    .KERNEL_DIM(K),
    .IN_DIM_L0 (D0),
    .IN_DIM_L1 (D1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic outs_t sample();
    outs_t s;
    s.clr      = bus.conv_clr;
    s.en       = bus.conv_en;
    s.bias     = bus.conv_bias;
    s.in_addr  = bus.in_mem_addr;
    s.w_addr   = bus.w_mem_addr;
    s.out_addr = bus.out_mem_addr;
    s.we       = bus.out_mem_we;
    s.busy     = bus.busy;
    s.done     = bus.done;
    return s;
  endfunction

  function automatic outs_t mk(input bit clr, input bit en, input int in_a, input int w_a,
                               input bit busy);
    outs_t e;
    e         = '0;
    e.clr     = clr;
    e.en      = en;
    e.in_addr = AW'(in_a);
    e.w_addr  = AW'(w_a);
    e.busy    = busy;
    return e;
  endfunction

  function automatic vec_t vec(input bit r, input bit s, input bit m, input outs_t e);
    vec_t v;
    v.rst   = r;
    v.start = s;
    v.mode  = m;
    v.exp   = e;
    return v;
  endfunction

  task automatic clear_tr();
    tr_mism = 0; tr_writes = 0; tr_dones = 0; tr_bias = 0;
    tr_done_cyc = -1; tr_cyc = 0; tr_max_in = 0;
  endtask

  // One clock: sample after the edge, tally, then drive the next inputs.
  task automatic step(input outs_t e, input bit noise, output outs_t a);
    @(posedge clk);
    #1;
    a = sample();
    if (a !== e) begin
      tr_mism++;
      if (tr_mism <= 3) $display("  trace diff at step %0d: got %p want %p", tr_cyc, a, e);
    end
    if (a.we)   tr_writes++;
    if (a.bias) tr_bias++;
    if (a.done) begin
      tr_dones++;
      tr_done_cyc = tr_cyc;
    end
    if (int'(a.in_addr) > tr_max_in) tr_max_in = int'(a.in_addr);
    tr_cyc++;
    if (noise) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.mode  = 1'($urandom_range(0, 1));
    end else begin
      bus.start = 1'b0;
    end
  endtask

  // Launch a map from IDLE and follow it pixel by pixel. With abort_pix >= 0 the
  // run stops after READ index abort_rd of that pixel and leaves rst=1 pending.
  task automatic run_map(input bit m, input bit noise, input int abort_pix, input int abort_rd,
                         input string tag);
    int    d, o, per, p7_first, p7_last;
    bit    aborted;
    outs_t e, a;
    d        = m ? D1 : D0;
    o        = d - K + 1;
    per      = K * K + 3 + BIAS;
    aborted  = 1'b0;
    p7_first = -1;
    p7_last  = -1;
    clear_tr();
    bus.start = 1'b1;
    bus.mode  = m;
    for (int p = 0; p < o * o && !aborted; p++) begin
      int ox, oy;
      ox = p % o;
      oy = p / o;
      step(mk(1, 0, 0, 0, 1), noise, a);
      for (int i = 0; i < K * K; i++) begin
        step(mk(0, i != 0, (oy + i / K) * d + ox + i % K, i, 1), noise, a);
        if (m && p == 7 && i == 0)     p7_first = int'(a.in_addr);
        if (m && p == 7 && i == K * K - 1) p7_last = int'(a.in_addr);
        if (p == abort_pix && i == abort_rd) begin
          aborted = 1'b1;
          break;
        end
      end
      if (!aborted) begin
        if (BIAS != 0) step(mk(0, 1, 0, K * K, 1), noise, a);
        e      = mk(0, 1, 0, 0, 1);
        e.bias = (BIAS != 0);
        step(e, noise, a);
        e          = mk(0, 0, 0, 0, 1);
        e.we       = 1'b1;
        e.out_addr = AW'(p);
        step(e, noise, a);
      end
    end
    if (aborted) begin
      check({tag, "_trace"}, tr_mism, 0);
      bus.start = 1'b0;
      rst       = 1'b1;
    end else begin
      e      = mk(0, 0, 0, 0, 1);
      e.done = 1'b1;
      step(e, 0, a);
      bus.start = 1'b1;            // held through DONE: must not restart
      bus.mode  = 1'($urandom_range(0, 1));
      step('0, 0, a);
      step('0, 0, a);
      check({tag, "_trace"},    tr_mism, 0);
      check({tag, "_writes"},   tr_writes, o * o);
      check({tag, "_dones"},    tr_dones, 1);
      check({tag, "_done_cyc"}, tr_done_cyc, o * o * per);
      check({tag, "_bias"},     tr_bias, BIAS != 0 ? o * o : 0);
      check({tag, "_max_in"},   tr_max_in, d * d - 1);
      if (m) begin
        check({tag, "_p7_first"}, p7_first, 7);
        check({tag, "_p7_last"},  p7_last, 59);
      end
    end
  endtask

  initial begin
    vec_t  vecs[11];
    outs_t a;
    int    cyc, last_in, gap;

    vecs[0]  = vec(1, 0, 0, '0);
    vecs[1]  = vec(1, 1, 1, '0);                 // reset beats start
    vecs[2]  = vec(1, 0, 0, '0);
    vecs[3]  = vec(0, 1, 0, mk(1, 0, 0, 0, 1));   // CLEAR
    vecs[4]  = vec(0, 0, 1, mk(0, 0, 0, 0, 1));   // READ 0, no conv_en yet
    vecs[5]  = vec(0, 1, 1, mk(0, 1, 1, 1, 1));   // start while busy ignored
    vecs[6]  = vec(0, 0, 0, mk(0, 1, 2, 2, 1));
    vecs[7]  = vec(0, 0, 1, mk(0, 1, 3, 3, 1));
    vecs[8]  = vec(0, 0, 0, mk(0, 1, 4, 4, 1));
    vecs[9]  = vec(0, 0, 0, mk(0, 1, 28, 5, 1));  // ky wraps into row 1
    vecs[10] = vec(0, 0, 0, mk(0, 1, 29, 6, 1));

    for (int i = 0; i < 11; i++) begin
      rst       = vecs[i].rst;
      bus.start = vecs[i].start;
      bus.mode  = vecs[i].mode;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), sample(), vecs[i].exp);
    end

    // Finish pixel 0: last READ address and first-write latency from CLEAR.
    bus.start = 1'b0;
    cyc       = 7;
    last_in   = -1;
    while (!bus.out_mem_we && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == K * K) last_in = int'(bus.in_mem_addr);
    end
    check("first_write_latency", cyc, 27 + BIAS);
    check("first_write_addr", bus.out_mem_addr, 0);
    check("first_write_en_low", bus.conv_en, 0);
    check("pix0_last_in", last_in, 116);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_after_write", sample(), '0);

    // Full layer-0 map with start/mode noise while busy.
    run_map(0, 1, -1, 0, "l0");

    // Reset in the middle of READ for pixel 100, stay quiet, then restart at 0.
    run_map(0, 1, 100, 12, "l0_abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("l0_abort_outputs", sample(), '0);
    clear_tr();
    for (int i = 0; i < 30; i++) step('0, 0, a);
    check("l0_abort_quiet", tr_mism + tr_writes + tr_dones, 0);
    run_map(0, 0, 1, 0, "l0_restart");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("l0_restart_rst", sample(), '0);

    // Random idle gaps and layer-1 maps with noisy inputs.
    for (int r = 0; r < 3; r++) begin
      gap = $urandom_range(1, 4);
      clear_tr();
      for (int g = 0; g < gap; g++) begin
        bus.mode = 1'($urandom_range(0, 1));
        step('0, 0, a);
      end
      check($sformatf("gap%0d_idle", r), tr_mism, 0);
      run_map(1, 1, -1, 0, $sformatf("l1_r%0d", r));
    end

    // Random mid-map reset on layer 1, then a clean map.
    run_map(1, 1, $urandom_range(0, 63), $urandom_range(0, K * K - 1), "l1_abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("l1_abort_outputs", sample(), '0);
    run_map(1, 0, -1, 0, "l1_after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
